pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline stage register, the successor to the fixed per-stage register bundles (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake, synchronous flush (bubble insertion), an optional two-entry skid mode that removes the combinational ready path, and saturating stall and bubble performance counters. Core stage boundaries instantiate one per stage, with control and data fields packed into the payload.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for every pipeline stage register instance.
package pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // A handshake transfer happens when both sides agree in the same cycle.
    function automatic logic is_xfer(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with flush, optional skid entry and
// saturating stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter bit          SKID  = 1'b1,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
);

    logic accept;
    logic out_xfer;

    assign accept   = is_xfer(in_valid, in_ready);
    assign out_xfer = is_xfer(out_valid, out_ready);

    if (SKID) begin : g_skid
        // Main entry drives the output; skid entry catches the one payload
        // that arrives while the downstream is stalled.
        stage_state_e     state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             valid_q, valid_d;
        logic             ready_q, ready_d;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = HALF;
                    end
                end
                HALF: begin
                    if (accept && out_xfer) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Flush kills everything held, including a same-cycle accept.
            if (flush) begin
                state_d = EMPTY;
            end
            valid_d = (state_d != EMPTY);
            ready_d = (state_d != FULL);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                valid_q <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                valid_q <= valid_d;
                ready_q <= ready_d;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign in_ready  = ready_q;
    end else begin : g_single
        logic [WIDTH-1:0] data_q, data_d;
        logic             valid_q, valid_d;

        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (accept) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else if (out_xfer) begin
                valid_d = 1'b0;
            end
            if (flush) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        // Can refill in the same cycle the current entry drains.
        assign in_ready  = !valid_q || out_ready;
        assign out_valid = valid_q;
        assign out_data  = data_q;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (out_valid && !out_ready),
        .clr_i   (cnt_clr),
        .count_o (stall_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (!out_valid),
        .clr_i   (cnt_clr),
        .count_o (bubble_count)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard on the selected instance.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        cnt_clr;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [31:0] od_a, od_b, od_c;
    logic [15:0] sc_a, bc_a, sc_b, bc_b;
    logic [1:0]  sc_c, bc_c;

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .stall_count(sc_a), .bubble_count(bc_a)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .stall_count(sc_b), .bubble_count(bc_b)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(1'b1), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
        .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
        .stall_count(sc_c), .bubble_count(bc_c)
    );

    int          sel;
    logic        s_ir, s_ov;
    logic [31:0] s_od;

    always_comb begin
        s_ir = ir_a;
        s_ov = ov_a;
        s_od = od_a;
        case (sel)
            1: begin s_ir = ir_b; s_ov = ov_b; s_od = od_b; end
            2: begin s_ir = ir_c; s_ov = ov_c; s_od = od_c; end
            default: ;
        endcase
    end

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_err = 0;
    int          n_chk = 0;

    // Issue side: record every accepted payload that a flush does not kill.
    always @(negedge clk) begin
        if (rst_n && in_valid && s_ir && !flush) exp_q.push_back(in_data);
    end

    // Monitor: every output transfer must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst_n && s_ov && out_ready) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected none", s_od);
            end else begin
                mon_exp = exp_q.pop_front();
                if (s_od !== mon_exp) begin
                    n_err++;
                    $display("FAIL sb_data: got %0h expected %0h", s_od, mon_exp);
                end
            end
        end
        if (rst_n && flush) exp_q.delete();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [31:0] d, input logic ordy,
                          input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic fl, input logic clr);
        set_in(iv, d, ordy, fl, clr);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset state and single-cycle latency
        sel = 0;
        do_reset();
        chk("rst_ov", 32'(ov_a), 32'd0);
        chk("rst_ir", 32'(ir_a), 32'd1);
        chk("rst_od", od_a, 32'd0);
        chk("rst_stall", 32'(sc_a), 32'd0);
        chk("rst_bubble", 32'(bc_a), 32'd0);
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("lat_ov", 32'(ov_a), 32'd1);
        chk("lat_od", od_a, 32'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("lat_ov_one_cycle", 32'(ov_a), 32'd0);
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("lat_bubble", 32'(bc_a), 32'd4);
        chk("lat_stall", 32'(sc_a), 32'd0);
        chk("lat_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure with skid absorption
        do_reset();
        drive(1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("bp_ir_drop", 32'(ir_a), 32'd0);
        drive(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("bp_ir_held", 32'(ir_a), 32'd0);
        drive(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("bp_ir_rise", 32'(ir_a), 32'd1);
        drive(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'd4, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp_stall", 32'(sc_a), 32'd3);
        chk("bp_ov_end", 32'(ov_a), 32'd0);
        chk("bp_drain", 32'(exp_q.size()), 32'd0);

        // Flush priority over accept and over output transfer
        do_reset();
        drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
        chk("fl_full", 32'(ir_a), 32'd0);
        drive(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0);
        chk("fl_ov", 32'(ov_a), 32'd0);
        chk("fl_ir", 32'(ir_a), 32'd1);
        drive(1'b1, 32'hD0, 1'b1, 1'b0, 1'b0);
        chk("fl_next_od", od_a, 32'hD0);
        drive(1'b1, 32'hE0, 1'b1, 1'b1, 1'b0);
        chk("fl_xfer_ov", 32'(ov_a), 32'd0);
        drive(1'b1, 32'hF0, 1'b1, 1'b0, 1'b0);
        chk("fl_after_od", od_a, 32'hF0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("fl_drain", 32'(exp_q.size()), 32'd0);

        // Single-register mode: ready follows out_ready while full
        sel = 1;
        do_reset();
        chk("s0_rst_ir", 32'(ir_b), 32'd1);
        drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
        chk("s0_od0", od_b, 32'h10);
        set_in(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        #1;
        chk("s0_ir_lo", 32'(ir_b), 32'd0);
        tick();
        chk("s0_hold", od_b, 32'h10);
        set_in(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_ir_hi", 32'(ir_b), 32'd1);
        tick();
        chk("s0_od1", od_b, 32'h11);
        drive(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
        chk("s0_od2", od_b, 32'h12);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("s0_ov_end", 32'(ov_b), 32'd0);
        chk("s0_drain", 32'(exp_q.size()), 32'd0);

        // Counter saturation and clear priority (2-bit counters)
        sel = 2;
        do_reset();
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_two", 32'(sc_c), 32'd2);
        repeat (4) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_stick", 32'(sc_c), 32'd3);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("sat_clr", 32'(sc_c), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("sat_after_clr", 32'(sc_c), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("sat_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while full
        sel = 0;
        do_reset();
        drive(1'b1, 32'h61, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h62, 1'b0, 1'b0, 1'b0);
        chk("ar_pre_stall", 32'(sc_a), 32'd1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("ar_ov", 32'(ov_a), 32'd0);
        chk("ar_stall", 32'(sc_a), 32'd0);
        chk("ar_bubble", 32'(bc_a), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("ar_ir", 32'(ir_a), 32'd1);
        drive(1'b1, 32'h63, 1'b1, 1'b0, 1'b0);
        chk("ar_od", od_a, 32'h63);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("ar_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
